// File: rtl/fpu_rr_arbiter.sv
// Round-robin front end that shares one FPU between NumReq requesters.
// Issues are stamped with the requester index as tag, and results are routed back by tag.
module fpu_rr_arbiter #(
    parameter  int NumReq         = 4,
    parameter  int Width          = 32,
    parameter  int MaxOutstanding = 4,
    localparam int IdxW           = $clog2(NumReq)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic [NumReq-1:0]                 req_valid_i,
    output logic [NumReq-1:0]                 req_ready_o,
    input  logic [NumReq-1:0][2:0][Width-1:0] req_operands_i,
    input  logic [NumReq-1:0][3:0]            req_op_i,
    input  logic [NumReq-1:0]                 req_op_mod_i,
    input  logic [NumReq-1:0][2:0]            req_rnd_mode_i,
    input  logic [NumReq-1:0][2:0]            req_src_fmt_i,
    input  logic [NumReq-1:0][2:0]            req_dst_fmt_i,
    input  logic [NumReq-1:0][1:0]            req_int_fmt_i,
    output logic [NumReq-1:0]                 rsp_valid_o,
    input  logic [NumReq-1:0]                 rsp_ready_i,
    output logic [Width-1:0]                  rsp_result_o,
    output logic [4:0]                        rsp_status_o,
    output logic [2:0][Width-1:0]             fpu_operands_o,
    output logic [3:0]                        fpu_op_o,
    output logic                              fpu_op_mod_o,
    output logic [2:0]                        fpu_rnd_mode_o,
    output logic [2:0]                        fpu_src_fmt_o,
    output logic [2:0]                        fpu_dst_fmt_o,
    output logic [1:0]                        fpu_int_fmt_o,
    output logic [IdxW-1:0]                   fpu_tag_o,
    output logic                              fpu_in_valid_o,
    input  logic                              fpu_in_ready_i,
    input  logic [Width-1:0]                  fpu_result_i,
    input  logic [4:0]                        fpu_status_i,
    input  logic [IdxW-1:0]                   fpu_tag_i,
    input  logic                              fpu_out_valid_i,
    output logic                              fpu_out_ready_o,
    output logic                              fpu_flush_o,
    output logic                              busy_o
);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                        r_state;
    logic [IdxW-1:0]               r_ptr;
    logic [IdxW-1:0]               r_grant;
    logic [NumReq-1:0][CntW-1:0]   r_cnt;
    logic                          r_rsp_err;

    logic                          w_kill;
    logic [NumReq-1:0]             w_elig;
    logic [NumReq-1:0]             w_inc;
    logic [NumReq-1:0]             w_dec;
    logic [NumReq-1:0]             w_cnt_zero;
    logic [NumReq-1:0][IdxW-1:0]   w_rot_idx;
    logic [IdxW-1:0]               w_pick;
    logic                          w_pick_valid;
    logic [IdxW-1:0]               w_sel;
    logic                          w_issue;
    logic                          w_tag_ok;
    logic                          w_err;

    assign w_kill = rst_i | flush_i;

    // w_rot_idx[k] is the k-th candidate when scanning cyclically from r_ptr.
    genvar gi;
    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_req
            assign w_elig[gi]     = req_valid_i[gi] && (r_cnt[gi] < CntW'(MaxOutstanding));
            assign w_rot_idx[gi]  = (int'(r_ptr) + gi >= NumReq) ? IdxW'(int'(r_ptr) + gi - NumReq)
                                                                 : IdxW'(int'(r_ptr) + gi);
            assign req_ready_o[gi] = w_issue && (w_sel == IdxW'(gi));
            assign rsp_valid_o[gi] = !w_kill && fpu_out_valid_i && (fpu_tag_i == IdxW'(gi));
            assign w_inc[gi]       = req_ready_o[gi];
            assign w_dec[gi]       = rsp_valid_o[gi] && rsp_ready_i[gi];
            assign w_cnt_zero[gi]  = (r_cnt[gi] == '0);
        end
    endgenerate

    // Scan from the far end so the closest eligible candidate wins.
    always_comb begin
        w_pick       = r_ptr;
        w_pick_valid = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (w_elig[w_rot_idx[k]]) begin
                w_pick       = w_rot_idx[k];
                w_pick_valid = 1'b1;
            end
        end
    end

    assign w_sel          = (r_state == HOLD) ? r_grant : w_pick;
    assign fpu_in_valid_o = !w_kill && ((r_state == HOLD) || w_pick_valid);
    assign w_issue        = fpu_in_valid_o && fpu_in_ready_i;

    assign fpu_tag_o      = w_sel;
    assign fpu_operands_o = req_operands_i[w_sel];
    assign fpu_op_o       = req_op_i[w_sel];
    assign fpu_op_mod_o   = req_op_mod_i[w_sel];
    assign fpu_rnd_mode_o = req_rnd_mode_i[w_sel];
    assign fpu_src_fmt_o  = req_src_fmt_i[w_sel];
    assign fpu_dst_fmt_o  = req_dst_fmt_i[w_sel];
    assign fpu_int_fmt_o  = req_int_fmt_i[w_sel];

    // During flush or reset the FPU output is drained without delivering anything.
    assign w_tag_ok        = (int'(fpu_tag_i) < NumReq);
    assign fpu_out_ready_o = w_kill || (w_tag_ok && rsp_ready_i[fpu_tag_i]);
    assign rsp_result_o    = fpu_result_i;
    assign rsp_status_o    = fpu_status_i;
    assign fpu_flush_o     = w_kill;
    assign busy_o          = !rst_i && ((|r_cnt) || (r_state == HOLD));
    assign w_err           = |(w_dec & ~w_inc & w_cnt_zero);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else if (flush_i) begin
            r_state <= IDLE;
        end else if (w_issue) begin
            r_state <= IDLE;
            r_ptr   <= (w_sel == IdxW'(NumReq - 1)) ? '0 : w_sel + 1'b1;
        end else if (fpu_in_valid_o) begin
            r_state <= HOLD;
            r_grant <= w_sel;
        end
    end

    // Issue and completion on the same requester cancel; a stray completion saturates at 0.
    always_ff @(posedge clk_i) begin
        if (w_kill) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i] && !w_cnt_zero[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= r_rsp_err | w_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!r_rsp_err);
        end
    end

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Bench for fpu_rr_arbiter: directed scenarios plus a random phase, all checked
// every cycle against a cycle-level behavioural model and an echo-stub FPU.
module tb_fpu_rr_arbiter;
    localparam int N    = 4;
    localparam int W    = 32;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, flush;
    logic [N-1:0]            req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N-1:0][2:0][W-1:0] req_operands;
    logic [N-1:0][3:0]       req_op;
    logic [N-1:0]            req_op_mod;
    logic [N-1:0][2:0]       req_rnd, req_src, req_dst;
    logic [N-1:0][1:0]       req_int;
    logic [W-1:0]            rsp_result, fpu_result;
    logic [4:0]              rsp_status, fpu_status;
    logic [2:0][W-1:0]       fpu_operands;
    logic [3:0]              fpu_op;
    logic                    fpu_op_mod;
    logic [2:0]              fpu_rnd, fpu_src, fpu_dst;
    logic [1:0]              fpu_int;
    logic [1:0]              fpu_tag_o_s, fpu_tag_i_s;
    logic                    fpu_in_valid, fpu_in_ready, fpu_out_valid, fpu_out_ready;
    logic                    fpu_flush, busy;

    fpu_rr_arbiter #(.NumReq(N), .Width(W), .MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_operands_i(req_operands), .req_op_i(req_op), .req_op_mod_i(req_op_mod),
        .req_rnd_mode_i(req_rnd), .req_src_fmt_i(req_src), .req_dst_fmt_i(req_dst),
        .req_int_fmt_i(req_int),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
        .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_op_mod_o(fpu_op_mod),
        .fpu_rnd_mode_o(fpu_rnd), .fpu_src_fmt_o(fpu_src), .fpu_dst_fmt_o(fpu_dst),
        .fpu_int_fmt_o(fpu_int), .fpu_tag_o(fpu_tag_o_s),
        .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
        .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_i_s),
        .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
        .fpu_flush_o(fpu_flush), .busy_o(busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding ops per requester, rotating priority start, frozen grant.
    int m_cnt [N];
    int m_ptr;
    bit m_hold;
    int m_grant;

    bit           e_in_valid, e_out_ready, e_busy, e_flush;
    int           e_g;
    logic [N-1:0] e_ready, e_rsp_valid;

    typedef struct {int tag; logic [W-1:0] res; int due;} op_t;
    op_t q[$];
    int  q_sel;
    bit  stub_auto;
    int  lat_min, lat_max;
    int  cyc;
    int  ops_left [N];
    int  acc_cnt [N];

    logic [N-1:0]      o_ready, o_rsp_valid;
    logic [1:0]        o_tag;
    logic              o_in_valid, o_out_ready, o_busy, o_flush;
    logic [2:0][W-1:0] o_ops;
    logic [W-1:0]      o_result;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic new_payload(input int i);
        req_operands[i][0] = $urandom;
        req_operands[i][1] = $urandom;
        req_operands[i][2] = $urandom;
        req_op[i]     = 4'($urandom_range(4, 0));
        req_op_mod[i] = 1'($urandom);
        req_rnd[i]    = 3'($urandom_range(4, 0));
        req_src[i]    = 3'($urandom_range(4, 0));
        req_dst[i]    = 3'($urandom_range(4, 0));
        req_int[i]    = 2'($urandom);
    endtask

    task automatic model_eval();
        bit any;
        any = 1'b0;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) any = 1'b1;
        e_in_valid  = 1'b0;
        e_g         = 0;
        e_ready     = '0;
        e_rsp_valid = '0;
        e_flush     = rst || flush;
        e_busy      = !rst && (m_hold || any);
        e_out_ready = 1'b1;
        if (e_flush) return;
        if (m_hold) begin
            e_in_valid = 1'b1;
            e_g        = m_grant;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!e_in_valid && req_valid[j] && m_cnt[j] < MAXO) begin
                    e_in_valid = 1'b1;
                    e_g        = j;
                end
            end
        end
        if (e_in_valid && fpu_in_ready) e_ready[e_g] = 1'b1;
        e_out_ready = rsp_ready[fpu_tag_i_s];
        if (fpu_out_valid) e_rsp_valid[fpu_tag_i_s] = 1'b1;
    endtask

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ptr  = 0;
            m_hold = 1'b0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_hold = 1'b0;
        end else begin
            if (e_in_valid && fpu_in_ready) begin
                m_cnt[e_g]++;
                m_ptr  = (e_g + 1) % N;
                m_hold = 1'b0;
            end else if (e_in_valid) begin
                m_hold  = 1'b1;
                m_grant = e_g;
            end
            if (fpu_out_valid && e_out_ready && m_cnt[fpu_tag_i_s] > 0) m_cnt[fpu_tag_i_s]--;
        end
    endtask

    // Echo stub: result = op0 + op1, returned after a random latency, any due entry first.
    task automatic stub_drive();
        int nd, pick;
        if (!stub_auto) return;
        nd    = 0;
        q_sel = -1;
        for (int k = 0; k < q.size(); k++) if (q[k].due <= cyc) nd++;
        if (nd > 0) begin
            pick = int'($urandom_range(nd - 1, 0));
            for (int k = 0; k < q.size(); k++) begin
                if (q[k].due <= cyc) begin
                    if (pick == 0 && q_sel < 0) q_sel = k;
                    pick--;
                end
            end
        end
        fpu_out_valid = (q_sel >= 0);
        if (q_sel >= 0) begin
            fpu_tag_i_s = 2'(q[q_sel].tag);
            fpu_result  = q[q_sel].res;
        end
        fpu_status = 5'($urandom);
    endtask

    task automatic stub_book();
        if (e_flush) begin
            q.delete();
        end else begin
            if (stub_auto && fpu_out_valid && e_out_ready && q_sel >= 0) q.delete(q_sel);
            if (e_in_valid && fpu_in_ready)
                q.push_back('{tag: e_g, res: req_operands[e_g][0] + req_operands[e_g][1],
                              due: cyc + int'($urandom_range(lat_max, lat_min))});
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) req_valid[i] = (ops_left[i] > 0);
        stub_drive();
        @(negedge clk);
        model_eval();
        chk("in_valid", 128'(fpu_in_valid), 128'(e_in_valid));
        chk("req_ready", 128'(req_ready), 128'(e_ready));
        if (e_in_valid) begin
            chk("tag", 128'(fpu_tag_o_s), 128'(e_g));
            chk("payload", 128'({fpu_operands, fpu_op, fpu_op_mod, fpu_rnd, fpu_src, fpu_dst, fpu_int}),
                128'({req_operands[e_g], req_op[e_g], req_op_mod[e_g], req_rnd[e_g],
                      req_src[e_g], req_dst[e_g], req_int[e_g]}));
        end
        chk("rsp_valid", 128'(rsp_valid), 128'(e_rsp_valid));
        chk("out_ready", 128'(fpu_out_ready), 128'(e_out_ready));
        chk("result", 128'({rsp_status, rsp_result}), 128'({fpu_status, fpu_result}));
        chk("busy", 128'(busy), 128'(e_busy));
        chk("flush_o", 128'(fpu_flush), 128'(e_flush));
        o_ready = req_ready; o_tag = fpu_tag_o_s; o_rsp_valid = rsp_valid;
        o_in_valid = fpu_in_valid; o_out_ready = fpu_out_ready; o_busy = busy;
        o_flush = fpu_flush; o_ops = fpu_operands; o_result = rsp_result;
        for (int i = 0; i < N; i++) acc_cnt[i] += int'(req_ready[i]);
        stub_book();
        acc = e_ready;
        model_update();
        for (int i = 0; i < N; i++) if (acc[i]) ops_left[i]--;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (acc[i]) new_payload(i);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || m_hold) && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_bound"}, 128'(n < 100), 128'(1));
        tick();
        chk(tag, 128'(o_busy), 128'(0));
    endtask

    initial begin
        logic [2:0][W-1:0] saved;
        rst = 1'b1; flush = 1'b0; req_valid = '0; rsp_ready = '1;
        fpu_in_ready = 1'b1; fpu_out_valid = 1'b0; fpu_tag_i_s = '0;
        fpu_result = '0; fpu_status = '0;
        stub_auto = 1'b0; lat_min = 2; lat_max = 2; cyc = 0; q_sel = -1;
        m_ptr = 0; m_hold = 1'b0; m_grant = 0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; ops_left[i] = 0; acc_cnt[i] = 0;
            new_payload(i);
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset: requests are visible but nothing may be granted.
        for (int i = 0; i < N; i++) ops_left[i] = 1;
        repeat (2) tick();
        chk("rst_ready", 128'(o_ready), 128'(0));
        chk("rst_flush", 128'(o_flush), 128'(1));
        chk("rst_busy", 128'(o_busy), 128'(0));
        for (int i = 0; i < N; i++) ops_left[i] = 0;
        rst = 1'b0;

        // Single ADD from requester 0 through a latency-2 echo stub.
        stub_auto = 1'b1;
        req_operands[0][0] = 32'h40A147AE;
        req_operands[0][1] = 32'h41800000;
        req_op[0] = 4'd2;
        ops_left[0] = 1;
        tick();
        chk("t1_tag", 128'(o_tag), 128'(0));
        chk("t1_ready", 128'(o_ready), 128'(4'b0001));
        tick();
        chk("t1_rsp_c1", 128'(o_rsp_valid), 128'(0));
        tick();
        chk("t1_rsp_c2", 128'(o_rsp_valid), 128'(4'b0001));
        chk("t1_result", 128'(o_result), 128'(32'h822147AE));
        tick();
        chk("t1_busy", 128'(o_busy), 128'(0));

        // All requesters continuously valid: equal share over 40 cycles.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < N; i++) begin acc_cnt[i] = 0; ops_left[i] = 10; end
        repeat (40) tick();
        for (int i = 0; i < N; i++) chk($sformatf("t2_share%0d", i), 128'(acc_cnt[i]), 128'(10));
        drain("t2_drain");

        // Back-pressure holds the grant on requester 2 while 1 and 3 wait.
        ops_left[1] = 1;
        tick();
        chk("t3_pre", 128'(o_ready), 128'(4'b0010));
        ops_left[1] = 1; ops_left[2] = 1; ops_left[3] = 1;
        saved = req_operands[2];
        fpu_in_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_hold_tag", 128'(o_tag), 128'(2));
            chk("t3_hold_ops", 128'(o_ops), 128'(saved));
            chk("t3_hold_valid", 128'(o_in_valid), 128'(1));
        end
        fpu_in_ready = 1'b1;
        tick();
        chk("t3_accept", 128'(o_ready), 128'(4'b0100));
        tick();
        chk("t3_next", 128'(o_ready), 128'(4'b1000));
        tick();
        chk("t3_last", 128'(o_ready), 128'(4'b0010));
        drain("t3_drain");

        // Outstanding limit: stub never answers.
        stub_auto = 1'b0; fpu_out_valid = 1'b0;
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        ops_left[1] = 6; ops_left[0] = 3;
        repeat (12) tick();
        chk("t4_req1", 128'(acc_cnt[1]), 128'(4));
        chk("t4_req0", 128'(acc_cnt[0]), 128'(3));
        chk("t4_blocked", 128'(o_ready), 128'(0));
        chk("t4_busy", 128'(o_busy), 128'(1));

        // Flush with ops in flight and a stale result presented.
        ops_left[1] = 0;
        flush = 1'b1; fpu_out_valid = 1'b1; fpu_tag_i_s = 2'd1; fpu_result = $urandom;
        tick();
        chk("t6_flush_o", 128'(o_flush), 128'(1));
        chk("t6_stale", 128'(o_rsp_valid), 128'(0));
        chk("t6_drain", 128'(o_out_ready), 128'(1));
        flush = 1'b0; fpu_out_valid = 1'b0;
        tick();
        chk("t6_busy", 128'(o_busy), 128'(0));

        // Out-of-order completion: DIV on 0, MUL on 3, MUL returns first under back-pressure.
        req_op[0] = 4'd4; ops_left[0] = 1;
        tick();
        chk("t5_div_tag", 128'(o_tag), 128'(0));
        req_op[3] = 4'd3; ops_left[3] = 1;
        tick();
        chk("t5_mul_tag", 128'(o_tag), 128'(3));
        fpu_out_valid = 1'b1; fpu_tag_i_s = 2'd3; fpu_result = 32'h3F800000; rsp_ready[3] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_held", 128'(o_rsp_valid), 128'(4'b1000));
            chk("t5_stall", 128'(o_out_ready), 128'(0));
        end
        rsp_ready[3] = 1'b1;
        tick();
        chk("t5_mul_ok", 128'(o_out_ready), 128'(1));
        fpu_tag_i_s = 2'd0; fpu_result = 32'h40000000;
        tick();
        chk("t5_div_route", 128'(o_rsp_valid), 128'(4'b0001));
        chk("t5_div_res", 128'(o_result), 128'(32'h40000000));
        fpu_out_valid = 1'b0;
        tick();
        chk("t5_busy", 128'(o_busy), 128'(0));
        q.delete();

        // Reset mid-operation also rewinds the rotation pointer.
        ops_left[2] = 1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ops_left[1] = 1; ops_left[3] = 1;
        tick();
        chk("t8_ptr_rewind", 128'(o_tag), 128'(1));
        tick();
        chk("t8_next", 128'(o_tag), 128'(3));

        // Random traffic, back-pressure, flushes and resets.
        stub_auto = 1'b1; lat_min = 1; lat_max = 6;
        for (int c = 0; c < 400; c++) begin
            fpu_in_ready = ($urandom_range(3, 0) != 0);
            rsp_ready    = 4'($urandom);
            flush        = ($urandom_range(63, 0) == 0);
            rst          = ($urandom_range(199, 0) == 0);
            for (int i = 0; i < N; i++)
                if (ops_left[i] == 0 && $urandom_range(2, 0) == 0) ops_left[i] = int'($urandom_range(4, 1));
            tick();
        end
        flush = 1'b0; rst = 1'b0; fpu_in_ready = 1'b1; rsp_ready = '1;
        for (int i = 0; i < N; i++) ops_left[i] = 0;
        drain("t7_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
